// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_pkg
//  Purpose  : Shared types and constants for the HPS-to-IO-bus bridge:
//             FSM state encoding, window/UART address map, default timing
//             and the byte-lane swap helpers used on both data directions.
//  Revision : 1.0  initial release
// ============================================================================
package io_bus_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } io_state_t;

    // Upper half of the lightweight HPS address window served by the bridge
    localparam logic [15:0] c_WINDOW_BASE = 16'hFF21;

    // 16550 UART register blocks inside the window
    localparam logic [15:0] c_UART0_OFFSET = 16'h0200;
    localparam logic [15:0] c_UART1_OFFSET = 16'h0210;
    localparam logic [15:0] c_UART2_OFFSET = 16'h0220;
    localparam logic [15:0] c_UART3_OFFSET = 16'h0230;

    localparam int c_DEFAULT_WAIT    = 3;
    localparam int c_DEFAULT_TIMEOUT = 255;

    // Avalon even byte [7:0] travels on IO D15-D8, odd byte [15:8] on D7-D0
    function automatic logic [15:0] write_lanes(input logic [15:0] wdata);
        return {wdata[7:0], wdata[15:8]};
    endfunction

    // Reverse mapping for reads; lanes not enabled come back as zero
    function automatic logic [15:0] read_lanes(input logic [15:0] io_data,
                                               input logic [1:0]  be);
        logic [15:0] v_rd;
        v_rd[7:0]  = be[0] ? io_data[15:8] : 8'h00;
        v_rd[15:8] = be[1] ? io_data[7:0]  : 8'h00;
        return v_rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : io_wait_counter
//  Purpose  : Loadable down-counter with zero flag.  Counts the programmed
//             ACCESS wait states and, when external wait is built in, the
//             stretch timeout.  Load has priority over decrement; the count
//             saturates at zero.
//  Revision : 1.0  initial release
// ============================================================================
module io_wait_counter
    import io_bus_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load, otherwise count down toward zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_bridge
//  Purpose  : Converts single Avalon-MM reads/writes in the 0xFF21_xxxx
//             window into timed SETUP / ACCESS / HOLD cycles on the 16-bit
//             asynchronous IO bus.  All IO-side outputs are registered.
//             Optional build macro IO_BRIDGE_EXTWAIT_EN adds IOWait_H
//             stretching with a TIMEOUT_CYCLES limit and Timeout_H pulse.
//  Revision : 1.0  initial release
// ============================================================================
module io_bus_bridge
    import io_bus_pkg::*;
#(
    parameter int WAIT_STATES    = c_DEFAULT_WAIT,
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT
) (
    input  logic        Clock,
    input  logic        Reset_H,
    input  logic [15:0] avs_address,
    input  logic [1:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [15:0] Address,
    output logic        IOSelect_H,
    output logic        ByteSelect_L,
    output logic        OddByteSelect_L,
    output logic        WE_L,
    output logic        OE_L,
    output logic [15:0] DataOut,
    output logic        DataOutEnable_H,
    input  logic [15:0] DataIn
`ifdef IO_BRIDGE_EXTWAIT_EN
    ,
    input  logic        IOWait_H,
    output logic        Timeout_H
`endif
);

`ifdef IO_BRIDGE_EXTWAIT_EN
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_CNT_W = (c_TO_W > 4) ? c_TO_W : 4;
    localparam logic [c_CNT_W-1:0] c_TO_LOAD = c_CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int c_CNT_W = 4;
`endif
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD   = c_CNT_W'(WAIT_STATES);
    localparam logic               c_TIMEOUT_LSB = TIMEOUT_CYCLES[0];

    io_state_t         r_state;
    io_state_t         w_state_next;

    logic [14:0]       r_addr_hi;
    logic [1:0]        r_be;
    logic              r_wr;
    logic [15:0]       r_wdata;

    logic [14:0]       w_src_addr_hi;
    logic [1:0]        w_src_be;
    logic              w_src_wr;
    logic [15:0]       w_src_wdata;
    logic              w_active_next;

    logic              w_cnt_load;
    logic [c_CNT_W-1:0] w_cnt_load_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_sample;

    logic [15:0]       r_readdata;
    logic [15:0]       r_address;
    logic              r_io_select;
    logic              r_bsel_l;
    logic              r_obsel_l;
    logic              r_we_l;
    logic              r_oe_l;
    logic [15:0]       r_data_out;
    logic              r_data_oe;

    // Address bit 0 is ignored (halfword aligned); TIMEOUT_CYCLES only
    // matters when external wait is built in
    logic              w_unused;
    assign w_unused = avs_address[0] ^ c_TIMEOUT_LSB;

`ifdef IO_BRIDGE_EXTWAIT_EN
    logic              r_stretch;
    logic              w_stretch_next;
    logic              w_timeout;
    logic              r_timeout;
`endif

    io_wait_counter #(
        .WIDTH        (c_CNT_W)
    ) u_wait_counter (
        .clk          (Clock),
        .rst          (Reset_H),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_load_val),
        .i_dec        (w_cnt_dec),
        .o_zero       (w_cnt_zero)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, counter control and read-sample / timeout decisions
    always_comb begin
        w_state_next   = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = c_WAIT_LOAD;
        w_cnt_dec      = 1'b0;
        w_sample       = 1'b0;
`ifdef IO_BRIDGE_EXTWAIT_EN
        w_stretch_next = r_stretch;
        w_timeout      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (avs_read || avs_write) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
                w_cnt_load   = 1'b1;
            end
            ACCESS: begin
`ifdef IO_BRIDGE_EXTWAIT_EN
                if (!r_stretch) begin
                    if (!w_cnt_zero) begin
                        w_cnt_dec = 1'b1;
                    end else if (IOWait_H) begin
                        w_stretch_next = 1'b1;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = c_TO_LOAD;
                    end else begin
                        w_sample     = 1'b1;
                        w_state_next = HOLD;
                    end
                end else if (!IOWait_H) begin
                    w_sample       = 1'b1;
                    w_stretch_next = 1'b0;
                    w_state_next   = HOLD;
                end else if (w_cnt_zero) begin
                    w_timeout      = 1'b1;
                    w_stretch_next = 1'b0;
                    w_state_next   = HOLD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
`else
                if (w_cnt_zero) begin
                    w_sample     = 1'b1;
                    w_state_next = HOLD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
`endif
            end
            HOLD: begin
                w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // On acceptance the IO outputs load straight from the Avalon request,
    // afterwards from the captured copy
    always_comb begin
        if (r_state == IDLE) begin
            w_src_addr_hi = avs_address[15:1];
            w_src_be      = avs_byteenable;
            w_src_wr      = avs_write;
            w_src_wdata   = avs_writedata;
        end else begin
            w_src_addr_hi = r_addr_hi;
            w_src_be      = r_be;
            w_src_wr      = r_wr;
            w_src_wdata   = r_wdata;
        end
        w_active_next = (w_state_next == SETUP) || (w_state_next == ACCESS) ||
                        (w_state_next == HOLD);
    end

    // Capture the request when it is accepted in IDLE; write wins a tie
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_addr_hi <= '0;
            r_be      <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
        end else if ((r_state == IDLE) && (avs_read || avs_write)) begin
            r_addr_hi <= avs_address[15:1];
            r_be      <= avs_byteenable;
            r_wr      <= avs_write;
            r_wdata   <= avs_writedata;
        end
    end

    // Registered IO bus outputs, decoded from the state being entered
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_address   <= '0;
            r_io_select <= 1'b0;
            r_bsel_l    <= 1'b1;
            r_obsel_l   <= 1'b1;
            r_we_l      <= 1'b1;
            r_oe_l      <= 1'b1;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
        end else begin
            r_address   <= w_active_next ? {w_src_addr_hi, 1'b0} : 16'h0000;
            r_io_select <= w_active_next;
            r_bsel_l    <= !(w_active_next && w_src_be[0]);
            r_obsel_l   <= !(w_active_next && w_src_be[1]);
            r_we_l      <= !((w_state_next == ACCESS) && w_src_wr);
            r_oe_l      <= !((w_state_next == ACCESS) && !w_src_wr);
            r_data_out  <= (w_active_next && w_src_wr) ? write_lanes(w_src_wdata) : 16'h0000;
            r_data_oe   <= w_active_next && w_src_wr;
        end
    end

    // Read data capture on the final ACCESS cycle (all-ones on timeout)
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_readdata <= '0;
`ifdef IO_BRIDGE_EXTWAIT_EN
        end else if (w_timeout) begin
            r_readdata <= 16'hFFFF;
`endif
        end else if (w_sample && !r_wr) begin
            r_readdata <= read_lanes(DataIn, r_be);
        end
    end

`ifdef IO_BRIDGE_EXTWAIT_EN
    // Stretch tracking and the one-cycle timeout pulse
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_stretch <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_stretch <= w_stretch_next;
            r_timeout <= w_timeout;
        end
    end

    assign Timeout_H = r_timeout;
`endif

    assign avs_waitrequest = (avs_read || avs_write) && (r_state != DONE);
    assign avs_readdata    = r_readdata;
    assign Address         = r_address;
    assign IOSelect_H      = r_io_select;
    assign ByteSelect_L    = r_bsel_l;
    assign OddByteSelect_L = r_obsel_l;
    assign WE_L            = r_we_l;
    assign OE_L            = r_oe_l;
    assign DataOut         = r_data_out;
    assign DataOutEnable_H = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_bus_bridge
//  Purpose  : Self-checking bench for io_bus_bridge (default build, W=3).
//             A transaction-level model predicts every IO output from the
//             cycle offset since acceptance; directed transfers add
//             hand-computed latency, strobe-length and data expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_bus_bridge;

    localparam int W = 3;

    logic        Clock = 1'b0;
    logic        Reset_H = 1'b1;
    logic [15:0] avs_address = '0;
    logic [1:0]  avs_byteenable = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [15:0] avs_writedata = '0;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [15:0] Address;
    logic        IOSelect_H;
    logic        ByteSelect_L;
    logic        OddByteSelect_L;
    logic        WE_L;
    logic        OE_L;
    logic [15:0] DataOut;
    logic        DataOutEnable_H;
    logic [15:0] DataIn = '0;
`ifdef IO_BRIDGE_EXTWAIT_EN
    logic        IOWait_H = 1'b0;
    logic        Timeout_H;
`endif

    io_bus_bridge #(
        .WAIT_STATES     (W),
        .TIMEOUT_CYCLES  (255)
    ) dut (
        .Clock           (Clock),
        .Reset_H         (Reset_H),
        .avs_address     (avs_address),
        .avs_byteenable  (avs_byteenable),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .Address         (Address),
        .IOSelect_H      (IOSelect_H),
        .ByteSelect_L    (ByteSelect_L),
        .OddByteSelect_L (OddByteSelect_L),
        .WE_L            (WE_L),
        .OE_L            (OE_L),
        .DataOut         (DataOut),
        .DataOutEnable_H (DataOutEnable_H),
        .DataIn          (DataIn)
`ifdef IO_BRIDGE_EXTWAIT_EN
        ,
        .IOWait_H        (IOWait_H),
        .Timeout_H       (Timeout_H)
`endif
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int overlap = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_k is the cycle offset from the request cycle T: 1 = setup,
    // 2..2+W = strobe, 3+W = hold, 4+W = completion.
    logic        m_edge = 1'b0;
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [1:0]  m_be = '0;
    logic [15:0] m_wd = '0;
    logic [15:0] m_rd = '0;

    always @(posedge Clock) begin
        m_edge <= 1'b1;
        if (Reset_H) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_rd   <= 16'h0000;
        end else if (!m_busy) begin
            if (avs_read || avs_write) begin
                m_busy <= 1'b1;
                m_k    <= 1;
                m_wr   <= avs_write;
                m_addr <= avs_address;
                m_be   <= avs_byteenable;
                m_wd   <= avs_writedata;
            end
        end else begin
            if ((m_k == 2 + W) && !m_wr)
                m_rd <= {m_be[1] ? DataIn[7:0] : 8'h00, m_be[0] ? DataIn[15:8] : 8'h00};
            if (m_k == 4 + W) m_busy <= 1'b0;
            else              m_k <= m_k + 1;
        end
    end

    logic e_active, e_strobe, e_done;

    // Compare every output against the model once per cycle
    always @(negedge Clock) begin
        if (m_edge) begin
            e_active = m_busy && (m_k <= 3 + W);
            e_strobe = m_busy && (m_k >= 2) && (m_k <= 2 + W);
            e_done   = m_busy && (m_k == 4 + W);
            chk("Address",  Address, e_active ? {m_addr[15:1], 1'b0} : 16'h0000);
            chk("IOSelect_H", 16'(IOSelect_H), 16'(e_active));
            chk("ByteSelect_L", 16'(ByteSelect_L), 16'(!(e_active && m_be[0])));
            chk("OddByteSelect_L", 16'(OddByteSelect_L), 16'(!(e_active && m_be[1])));
            chk("WE_L", 16'(WE_L), 16'(!(e_strobe && m_wr)));
            chk("OE_L", 16'(OE_L), 16'(!(e_strobe && !m_wr)));
            chk("DataOut", DataOut, (e_active && m_wr) ? {m_wd[7:0], m_wd[15:8]} : 16'h0000);
            chk("DataOutEnable_H", 16'(DataOutEnable_H), 16'(e_active && m_wr));
            chk("avs_waitrequest", 16'(avs_waitrequest), 16'((avs_read || avs_write) && !e_done));
            chk("avs_readdata", avs_readdata, m_rd);
            if (!WE_L && !OE_L) overlap++;
        end
    end

    // ---------------- directed stimulus ----------------
    int          x_treq, x_tdone, x_we, x_oe, x_sel;
    logic [15:0] x_addr, x_dout, x_rd;
    logic        x_bsl, x_obsl;

    // Called at posedge+1; returns at posedge+1 after completion, request still up
    task automatic xfer(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
        logic got;
        avs_read = rd; avs_write = wr; avs_address = a;
        avs_byteenable = be; avs_writedata = wd;
        x_treq = cyc; x_tdone = -1; x_we = 0; x_oe = 0; x_sel = 0;
        x_addr = '0; x_dout = '0; x_rd = '0; x_bsl = 1'b1; x_obsl = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (!WE_L) x_we++;
            if (!OE_L) x_oe++;
            if (!ByteSelect_L || !OddByteSelect_L) x_sel++;
            if (IOSelect_H && !got) begin
                got = 1'b1; x_addr = Address; x_dout = DataOut;
                x_bsl = ByteSelect_L; x_obsl = OddByteSelect_L;
            end
            if (!avs_waitrequest) begin
                x_tdone = cyc; x_rd = avs_readdata;
                break;
            end
        end
        if (x_tdone < 0) begin
            total++; bad++;
            $display("FAIL xfer_timeout: got no completion want completion within 40 cycles");
        end
        @(posedge Clock); #1;
    endtask

    task automatic drop();
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    int t_first_done;

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        Reset_H = 1'b0;
        @(negedge Clock);
        chk("rst_Address", Address, 16'h0000);
        chk("rst_selects", {14'd0, ByteSelect_L, OddByteSelect_L}, 16'h0003);
        chk("rst_strobes", {14'd0, WE_L, OE_L}, 16'h0003);
        chk("rst_readdata", avs_readdata, 16'h0000);
        @(posedge Clock); #1;

        // Write 0x00AB, even lane only, UART0
        xfer(1'b0, 1'b1, 16'h0200, 2'b01, 16'h00AB);
        chk("w1_latency", 16'(x_tdone - x_treq), 16'd7);
        chk("w1_we_cycles", 16'(x_we), 16'd4);
        chk("w1_oe_cycles", 16'(x_oe), 16'd0);
        chk("w1_addr", x_addr, 16'h0200);
        chk("w1_dout_hi", {8'h00, x_dout[15:8]}, 16'h00AB);
        chk("w1_sel", {14'd0, x_bsl, x_obsl}, 16'h0001);
        drop();
        @(posedge Clock); #1;

        // Read 0x0214 even lane
        DataIn = 16'h5A00;
        xfer(1'b1, 1'b0, 16'h0214, 2'b01, 16'h0000);
        chk("r1_latency", 16'(x_tdone - x_treq), 16'd7);
        chk("r1_addr", x_addr, 16'h0214);
        chk("r1_readdata", x_rd, 16'h005A);
        chk("r1_oe_cycles", 16'(x_oe), 16'd4);
        chk("r1_we_cycles", 16'(x_we), 16'd0);
        drop();
        @(posedge Clock); #1;

        // Back-to-back write then read; odd address bit dropped
        DataIn = 16'h00C3;
        xfer(1'b0, 1'b1, 16'h0231, 2'b11, 16'h1234);
        t_first_done = x_tdone;
        chk("b2b_w_addr", x_addr, 16'h0230);
        chk("b2b_w_dout", x_dout, 16'h3412);
        xfer(1'b1, 1'b0, 16'h0222, 2'b10, 16'h0000);
        chk("b2b_gap", 16'(x_treq - t_first_done), 16'd1);
        chk("b2b_r_done", 16'(x_tdone - t_first_done), 16'd8);
        chk("b2b_r_readdata", x_rd, 16'hC300);
        drop();
        @(posedge Clock); #1;

        // No byte enables: full cycle, no device selected
        DataIn = 16'hFFFF;
        xfer(1'b1, 1'b0, 16'h0210, 2'b00, 16'h0000);
        chk("be0_sel_cycles", 16'(x_sel), 16'd0);
        chk("be0_latency", 16'(x_tdone - x_treq), 16'd7);
        chk("be0_readdata", x_rd, 16'h0000);
        drop();
        @(posedge Clock); #1;

        // Read and write together: treated as a write
        xfer(1'b1, 1'b1, 16'h0220, 2'b10, 16'h7700);
        chk("rw_we_cycles", 16'(x_we), 16'd4);
        chk("rw_oe_cycles", 16'(x_oe), 16'd0);
        chk("rw_dout", x_dout, 16'h0077);
        chk("rw_sel", {14'd0, x_bsl, x_obsl}, 16'h0002);
        drop();
        @(posedge Clock); #1;

        // Both lanes swapped on read
        DataIn = 16'hBEEF;
        xfer(1'b1, 1'b0, 16'h0230, 2'b11, 16'h0000);
        chk("r2_readdata", x_rd, 16'hEFBE);
        drop();
        @(posedge Clock); #1;

        // Reset during ACCESS
        avs_write = 1'b1; avs_address = 16'h0200; avs_byteenable = 2'b11;
        avs_writedata = 16'h5555;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        chk("mid_we_active", 16'(WE_L), 16'd0);
        Reset_H = 1'b1;
        @(posedge Clock); #1;
        chk("mid_strobes", {14'd0, WE_L, OE_L}, 16'h0003);
        chk("mid_iosel", 16'(IOSelect_H), 16'd0);
        chk("mid_waitreq", 16'(avs_waitrequest), 16'd1);
        @(posedge Clock); #1;
        Reset_H = 1'b0;
        drop();
        @(posedge Clock); #1;

        // Recovery after reset
        xfer(1'b0, 1'b1, 16'h0200, 2'b01, 16'h00AB);
        chk("rec_latency", 16'(x_tdone - x_treq), 16'd7);
        chk("rec_we_cycles", 16'(x_we), 16'd4);
        drop();
        repeat (3) @(posedge Clock);
        #1;

        chk("strobe_overlap", 16'(overlap), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
